// File: rtl/video_dram_readout_sequencer.sv
// Video DRAM readout sequencer: an 8-clock slot either fetches one byte per plane
// (RAS/CAS on a multiplexed row/column address) or does two RAS-only refreshes during blanking.
module video_dram_readout_sequencer (
    input  logic        clk,
    input  logic        rst_al,
    input  logic [13:0] avax,
    input  logic [13:0] avbx,
    input  logic        blank_al,
    input  logic        flip,
    input  logic [7:0]  da_in,
    input  logic [7:0]  db_in,
    output logic [6:0]  ma,
    output logic        ras_a_al,
    output logic        cas_a_al,
    output logic        ras_b_al,
    output logic        cas_b_al,
    output logic        load_al,
    output logic        pix_a,
    output logic        pix_b
);

    // SLOT_NONE exists only before the first slot after reset: it loads zeros like
    // a refresh slot but must not advance the refresh counter.
    typedef enum logic [1:0] {SLOT_NONE, SLOT_VIDEO, SLOT_REFRESH} slot_e;

    logic [2:0] phase;
    slot_e      mode;
    logic [6:0] col_a;
    logic [13:0] addr_b;
    logic [6:0] ref_cnt;
    logic [6:0] ref_inc;
    logic [6:0] ref_next;
    logic [7:0] da_lat;
    logic [7:0] sr_a;
    logic [7:0] sr_b;
    logic       flip_lat;

    assign ref_inc  = ref_cnt + 7'd1;
    // The second RAS-only cycle of a refresh slot ends at the next phase 0.
    assign ref_next = (mode == SLOT_REFRESH) ? ref_inc : ref_cnt;

    assign pix_a = flip_lat ? sr_a[0] : sr_a[7];
    assign pix_b = flip_lat ? sr_b[0] : sr_b[7];

    always_ff @(posedge clk or negedge rst_al) begin
        if (!rst_al) begin
            phase    <= 3'd0;
            mode     <= SLOT_NONE;
            col_a    <= 7'd0;
            addr_b   <= 14'd0;
            ref_cnt  <= 7'd0;
            da_lat   <= 8'd0;
            sr_a     <= 8'd0;
            sr_b     <= 8'd0;
            flip_lat <= 1'b0;
            ma       <= 7'd0;
            ras_a_al <= 1'b1;
            cas_a_al <= 1'b1;
            ras_b_al <= 1'b1;
            cas_b_al <= 1'b1;
            load_al  <= 1'b1;
        end else begin
            // NOTE: every register here uses <= so all phase decisions see the pre-edge state.
            phase <= phase + 3'd1;
            if (phase == 3'd0) begin
                col_a    <= avax[13:7];
                addr_b   <= avbx;
                mode     <= blank_al ? SLOT_VIDEO : SLOT_REFRESH;
                ref_cnt  <= ref_next;
                ma       <= blank_al ? avax[6:0] : ref_next;
                ras_a_al <= 1'b1;
                cas_a_al <= 1'b1;
                ras_b_al <= 1'b1;
                cas_b_al <= 1'b1;
                load_al  <= 1'b0;
                if (mode == SLOT_VIDEO) begin
                    sr_a     <= da_lat;
                    sr_b     <= db_in;
                    flip_lat <= flip;
                end else begin
                    sr_a <= 8'd0;
                    sr_b <= 8'd0;
                end
            end else begin
                load_al <= 1'b1;
                if (flip_lat) begin
                    sr_a <= {1'b0, sr_a[7:1]};
                    sr_b <= {1'b0, sr_b[7:1]};
                end else begin
                    sr_a <= {sr_a[6:0], 1'b0};
                    sr_b <= {sr_b[6:0], 1'b0};
                end
                if (mode == SLOT_VIDEO) begin
                    case (phase)
                        3'd1: ras_a_al <= 1'b0;
                        3'd2: ma <= col_a;
                        3'd3: cas_a_al <= 1'b0;
                        3'd4: begin
                            da_lat   <= da_in;
                            ras_a_al <= 1'b1;
                            cas_a_al <= 1'b1;
                            ma       <= addr_b[6:0];
                        end
                        3'd5: ras_b_al <= 1'b0;
                        3'd6: ma <= addr_b[13:7];
                        3'd7: cas_b_al <= 1'b0;
                        default: ;
                    endcase
                end else if (mode == SLOT_REFRESH) begin
                    case (phase)
                        3'd1, 3'd5: begin
                            ras_a_al <= 1'b0;
                            ras_b_al <= 1'b0;
                        end
                        3'd4: begin
                            ras_a_al <= 1'b1;
                            ras_b_al <= 1'b1;
                            ref_cnt  <= ref_inc;
                            ma       <= ref_inc;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_video_dram_readout_sequencer.sv
// Self-checking bench: table of video slots plus refresh, wrap and mid-slot reset sequences;
// expected pixel bytes go through a scoreboard queue with one-slot latency.
module tb_video_dram_readout_sequencer;

    logic        clk;
    logic        rst_al;
    logic [13:0] avax;
    logic [13:0] avbx;
    logic        blank_al;
    logic        flip;
    logic [7:0]  da_in;
    logic [7:0]  db_in;
    logic [6:0]  ma;
    logic        ras_a_al;
    logic        cas_a_al;
    logic        ras_b_al;
    logic        cas_b_al;
    logic        load_al;
    logic        pix_a;
    logic        pix_b;

    video_dram_readout_sequencer dut (
        .clk(clk), .rst_al(rst_al), .avax(avax), .avbx(avbx), .blank_al(blank_al),
        .flip(flip), .da_in(da_in), .db_in(db_in), .ma(ma),
        .ras_a_al(ras_a_al), .cas_a_al(cas_a_al), .ras_b_al(ras_b_al), .cas_b_al(cas_b_al),
        .load_al(load_al), .pix_a(pix_a), .pix_b(pix_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0]     avax;
        logic [13:0]     avbx;
        logic [7:0]      da;
        logic [7:0]      db;
        logic            flip;
        logic [3:0][6:0] ma;   // MA after edges 0-1, 2-3, 4-5, 6-7
        logic [7:0]      pa;   // pixels in time order, first pixel in bit 7
        logic [7:0]      pb;
    } vec_t;

    typedef struct packed {
        logic [7:0] pa;
        logic [7:0] pb;
    } pix_t;

    // {ras_a, cas_a, ras_b, cas_b} after the edge at each phase
    localparam logic [3:0] VID_STB [8] = '{4'b1111, 4'b0111, 4'b0111, 4'b0011,
                                           4'b1111, 4'b1101, 4'b1101, 4'b1100};
    localparam logic [3:0] REF_STB [8] = '{4'b1111, 4'b0101, 4'b0101, 4'b0101,
                                           4'b1111, 4'b0101, 4'b0101, 4'b0101};

    int         n_total;
    int         n_pass;
    pix_t       sb[$];
    logic [6:0] exp_ref;
    logic [7:0] prev_db;
    logic       prev_flip;
    vec_t       vecs [6];
    vec_t       idle;

    function automatic vec_t mk(input logic [13:0] ax, input logic [13:0] bx,
                                input logic [7:0] da, input logic [7:0] db, input logic fl,
                                input logic [6:0] m0, input logic [6:0] m1,
                                input logic [6:0] m2, input logic [6:0] m3,
                                input logic [7:0] pa, input logic [7:0] pb);
        vec_t v;
        v.avax = ax; v.avbx = bx; v.da = da; v.db = db; v.flip = fl;
        v.ma[0] = m0; v.ma[1] = m1; v.ma[2] = m2; v.ma[3] = m3;
        v.pa = pa; v.pb = pb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_al = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_strobes", {ras_a_al, cas_a_al, ras_b_al, cas_b_al}, 4'b1111);
        check("reset_ma", ma, 7'd0);
        check("reset_load_al", load_al, 1'b1);
        check("reset_pix", {pix_a, pix_b}, 2'b00);
        rst_al = 1'b1;
        sb.delete();
        sb.push_back(pix_t'(16'h0000));
        exp_ref   = 7'd0;
        prev_db   = 8'h00;
        prev_flip = 1'b0;
    endtask

    // Runs one 8-clock slot starting at a negedge just before its phase-0 edge.
    task automatic run_slot(input logic video, input vec_t v);
        pix_t cur;
        pix_t nxt;
        cur = '0;
        for (int p = 0; p < 8; p++) begin
            if (p == 0) begin
                avax = v.avax; avbx = v.avbx; blank_al = video;
                db_in = prev_db; flip = prev_flip;
            end else begin
                avax = 14'($urandom); avbx = 14'($urandom); blank_al = 1'($urandom);
                db_in = 8'($urandom); flip = 1'($urandom);
            end
            da_in = (p == 4) ? v.da : 8'($urandom);
            tick();
            if (p == 0) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard at %0t: got empty queue expected an entry", $time);
                end else begin
                    cur = sb.pop_front();
                end
                nxt.pa = video ? v.pa : 8'h00;
                nxt.pb = video ? v.pb : 8'h00;
                sb.push_back(nxt);
            end
            check("strobes", {ras_a_al, cas_a_al, ras_b_al, cas_b_al},
                  video ? VID_STB[p] : REF_STB[p]);
            check("ma", ma, video ? v.ma[p/2] : ((p < 4) ? exp_ref : exp_ref + 7'd1));
            check("load_al", load_al, p != 0);
            check("pix_a", pix_a, cur.pa[7-p]);
            check("pix_b", pix_b, cur.pb[7-p]);
        end
        if (video) begin
            prev_db   = v.db;
            prev_flip = v.flip;
        end else begin
            exp_ref = exp_ref + 7'd2;
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        avax = '0; avbx = '0; blank_al = 1'b1; flip = 1'b0; da_in = '0; db_in = '0;

        vecs[0] = mk(14'h2A55, 14'h0081, 8'hA5, 8'h3C, 1'b0, 7'h55, 7'h54, 7'h01, 7'h01, 8'hA5, 8'h3C);
        vecs[1] = mk(14'h2A55, 14'h0081, 8'hA5, 8'h3C, 1'b1, 7'h55, 7'h54, 7'h01, 7'h01, 8'hA5, 8'h3C);
        vecs[2] = mk(14'h3FFF, 14'h0000, 8'h12, 8'hF0, 1'b1, 7'h7F, 7'h7F, 7'h00, 7'h00, 8'h48, 8'h0F);
        vecs[3] = mk(14'h0080, 14'h3F80, 8'h01, 8'h80, 1'b0, 7'h00, 7'h01, 7'h00, 7'h7F, 8'h01, 8'h80);
        vecs[4] = mk(14'h1234, 14'h2D6B, 8'h6E, 8'h0B, 1'b1, 7'h34, 7'h24, 7'h6B, 7'h5A, 8'h76, 8'hD0);
        vecs[5] = mk(14'h0000, 14'h0000, 8'hFF, 8'hFF, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00, 8'hFF, 8'hFF);
        idle    = mk(14'h1555, 14'h2AAA, 8'h5A, 8'hC3, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00, 8'h00, 8'h00);

        // Reset, then table of video slots; the last one's pixels drain during the first refresh.
        do_reset();
        for (int i = 0; i < 6; i++) run_slot(1'b1, vecs[i]);

        // Two refresh slots (MA 0..3), then a video slot that must shift zeros.
        run_slot(1'b0, idle);
        run_slot(1'b0, idle);
        run_slot(1'b1, vecs[2]);
        run_slot(1'b1, vecs[4]);

        // Mid-slot reset with RAS_A and CAS_A low.
        do_reset();
        avax = 14'h2A55; avbx = 14'h0081; blank_al = 1'b1;
        repeat (4) tick();
        check("midrst_pre_strobes", {ras_a_al, cas_a_al, ras_b_al, cas_b_al}, 4'b0011);
        check("midrst_pre_ma", ma, 7'h54);
        #2 rst_al = 1'b0;
        #1;
        check("midrst_strobes", {ras_a_al, cas_a_al, ras_b_al, cas_b_al}, 4'b1111);
        check("midrst_ma", ma, 7'd0);
        check("midrst_load_al", load_al, 1'b1);
        @(negedge clk);
        check("midrst_hold_ma", ma, 7'd0);
        rst_al = 1'b1;
        avax = 14'h1234;
        tick();
        check("midrst_restart_load_al", load_al, 1'b0);
        check("midrst_restart_ma", ma, 7'h34);
        check("midrst_restart_strobes", {ras_a_al, cas_a_al, ras_b_al, cas_b_al}, 4'b1111);
        tick();
        check("midrst_ph1_strobes", {ras_a_al, cas_a_al, ras_b_al, cas_b_al}, 4'b0111);
        tick();
        check("midrst_ph2_ma", ma, 7'h24);
        @(negedge clk);

        // Refresh counter wrap: 64 slots cover MA 0..127, the 65th starts again at 0.
        do_reset();
        for (int i = 0; i < 65; i++) run_slot(1'b0, idle);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
